// File: rtl/output_port_uart_tx_pkg.sv
// Shared constants for the CPU output-port UART transmitter.
// Hex-text mode constants and helper exist only when OUTPUT_PORT_HEX_EN is defined.
package output_port_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

`ifdef OUTPUT_PORT_HEX_EN
    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;

    // Four hex digits followed by CR LF.
    localparam int BYTES_PER_WORD = 6;

    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return ASCII_UPPER_A + ({4'h0, nib} - 8'd10);
    endfunction
`else
    localparam int BYTES_PER_WORD = 2;
`endif

endpackage

// File: rtl/output_port_uart_tx_sync_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted only when a pop
// happens on the same edge, otherwise it is dropped and flagged.
module output_port_uart_tx_sync_fifo #(
    parameter int DataWidth     = 16,
    parameter int FifoAddrWidth = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DataWidth-1:0] din,
    output logic [DataWidth-1:0] dout,
    output logic                 full,
    output logic                 empty,
    output logic                 drop
);

    localparam int Depth = 1 << FifoAddrWidth;

    logic [DataWidth-1:0]     mem_q [Depth];
    logic [FifoAddrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [FifoAddrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [FifoAddrWidth:0]   count_q, count_d;
    logic                     push_ok;
    logic                     pop_ok;

    assign full    = (count_q == (FifoAddrWidth + 1)'(Depth));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset so it maps onto RAM; pointers alone define validity.
    always_ff @(posedge Clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/output_port_uart_tx.sv
// Captures CPU output-port words into a FIFO and sends them 8N1 on Tx, high byte first.
// Define OUTPUT_PORT_HEX_EN to send each word as four ASCII hex digits plus CR LF.
module output_port_uart_tx
    import output_port_uart_tx_pkg::*;
#(
    parameter int DataWidth     = 16,
    parameter int ClkPerBit     = 104,
    parameter int FifoAddrWidth = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 OUT_Ld,
    input  logic [DataWidth-1:0] DIn,
    output logic                 Tx,
    output logic                 Busy,
    output logic                 Full,
    output logic                 Empty,
    output logic                 Overflow
);

    localparam int BaudWidth = $clog2(ClkPerBit);

    tx_state_e              state_q, state_d;
    logic [BaudWidth-1:0]   baud_q, baud_d;
    logic [2:0]             bit_q, bit_d;
    logic [2:0]             byte_q, byte_d;
    logic [DataWidth-1:0]   word_q, word_d;
    logic                   tx_q, tx_d;
    logic                   overflow_q, overflow_d;

    logic [DataWidth-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_drop;
    logic                   pop;
    logic                   baud_end;
    logic [7:0]             cur_byte;

    output_port_uart_tx_sync_fifo #(
        .DataWidth     (DataWidth),
        .FifoAddrWidth (FifoAddrWidth)
    ) u_fifo (
        .Clk   (Clk),
        .Reset (Reset),
        .push  (OUT_Ld),
        .pop   (pop),
        .din   (DIn),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign pop      = (state_q == ST_IDLE) && !fifo_empty;
    assign baud_end = (baud_q == BaudWidth'(ClkPerBit - 1));

`ifdef OUTPUT_PORT_HEX_EN
    always_comb begin
        case (byte_q)
            3'd0:    cur_byte = hex_to_ascii(word_q[15:12]);
            3'd1:    cur_byte = hex_to_ascii(word_q[11:8]);
            3'd2:    cur_byte = hex_to_ascii(word_q[7:4]);
            3'd3:    cur_byte = hex_to_ascii(word_q[3:0]);
            3'd4:    cur_byte = ASCII_CR;
            default: cur_byte = ASCII_LF;
        endcase
    end
`else
    assign cur_byte = (byte_q == 3'd0) ? word_q[15:8] : word_q[7:0];
`endif

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        word_d     = word_q;
        tx_d       = 1'b1;
        overflow_d = overflow_q | fifo_drop;

        // Tx is registered from the current state, so the line trails the FSM by one cycle.
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    word_d  = fifo_dout;
                    byte_d  = 3'd0;
                    bit_d   = 3'd0;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                tx_d   = 1'b0;
                baud_d = baud_q + BaudWidth'(1);
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_d   = cur_byte[bit_q];
                baud_d = baud_q + BaudWidth'(1);
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        bit_d   = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_q + BaudWidth'(1);
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(UART_STOP_BITS - 1)) begin
                        bit_d = 3'd0;
                        if (byte_q == 3'(BYTES_PER_WORD - 1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            byte_d  = byte_q + 3'd1;
                            state_d = ST_START;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            word_q     <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign Tx       = tx_q;
    assign Busy     = !fifo_empty || (state_q != ST_IDLE);
    assign Full     = fifo_full;
    assign Empty    = fifo_empty;
    assign Overflow = overflow_q;

endmodule

// File: doc/output_port_uart_tx.md
Name: output_port_uart_tx

Overview:
- Consumer end of the CPU output port. Captures each word the CPU strobes into its output register.
- Buffers captured words in a small synchronous FIFO.
- Serialises each word onto a single UART TX pin (8N1, LSB first) so program output reaches a host terminal.
- Sits beside the CPU at board top level, driven by the same OUT_Ld strobe and data that load the output register.

Parameters:
- DataWidth, 16, width of a captured word; fixed at 16 (two bytes per word).
- ClkPerBit, 104, clock cycles per UART bit; minimum 2.
- FifoAddrWidth, 2, log2 of FIFO depth (default depth 4).

Ports:
- Clk, input, 1, system clock; all state changes on the rising edge.
- Reset, input, 1, synchronous, active-high; clears all state.
- OUT_Ld, input, 1, one-cycle capture strobe from the CPU control matrix.
- DIn, input, DataWidth, word to capture; sampled when OUT_Ld=1.
- Tx, output, 1, UART serial line; idles high.
- Busy, output, 1, high while the FIFO is non-empty or the FSM is not IDLE.
- Full, output, 1, FIFO holds its maximum number of words.
- Empty, output, 1, FIFO holds no words.
- Overflow, output, 1, sticky; set when a word is dropped; cleared only by Reset.

Behaviour:
- Reset (synchronous, active-high) takes effect at the next edge:
  - Tx=1, Busy=0, Full=0, Empty=1, Overflow=0.
  - FIFO pointers and count zeroed; FSM=IDLE; baud, bit and byte counters zeroed.
  - Reset mid-frame aborts the frame; Tx=1 on that edge; buffered words are discarded.
- Push: OUT_Ld=1 writes DIn at the write pointer; write pointer wraps modulo depth.
- Pop: occurs when FSM=IDLE and Empty=0; the word is loaded into the TX word register and the read pointer advances.
- Full with push and pop in the same cycle: the push is accepted, count is unchanged, Overflow is not set.
- Full with OUT_Ld=1 and no pop: the word is dropped and Overflow is set.
- FSM states:
  - IDLE: Tx=1; on pop, go to START with byte index 0.
  - START: Tx=0 for ClkPerBit cycles, then DATA.
  - DATA: 8 bits LSB first, each held ClkPerBit cycles; bit counter 0..7; then STOP.
  - STOP: Tx=1 for ClkPerBit cycles.
    - If more bytes remain in the word, increment byte index and go to START (no idle gap).
    - Otherwise go to IDLE.
- Byte order: high byte (DIn[15:8]) first, then the low byte.
- Latency: for an OUT_Ld edge N into an empty FIFO:
  - Pop at edge N+1.
  - Tx falls at edge N+2.
  - A word occupies exactly 20*ClkPerBit cycles on the line.
- Back-to-back words: the next pop happens in the IDLE cycle after STOP, giving exactly one idle-high cycle between words.
- Baud counter counts 0..ClkPerBit-1 and is reset on every state entry; its width is $clog2(ClkPerBit).
- Busy is combinational: !Empty or FSM != IDLE.

Optional Feature:
- Macro: OUTPUT_PORT_HEX_EN.
- Defined:
  - Each word is sent as six ASCII characters: four uppercase hex nibbles, MSB nibble first, then CR (0x0D) and LF (0x0A).
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - Byte index runs 0..5; a word occupies 60*ClkPerBit cycles.
- Undefined: raw two-byte mode as above; no hex conversion logic is synthesised.

Decomposition:
- Shared constants file (alongside the sequence-control constants):
  - FSM state encodings: IDLE, START, DATA, STOP.
  - UART frame constants: 8 data bits, 1 stop bit.
  - Hex-mode characters: CR, LF, ASCII '0' and 'A' offsets.
- One sub-module, sync_fifo:
  - Parameterised on DataWidth and FifoAddrWidth.
  - Provides push, pop, Full, Empty and the simultaneous push/pop-when-full rule.
- The TX FSM, counters and byte selection live in output_port_uart_tx.

Test Plan:
- ClkPerBit=4 throughout.
- Reset held 3 cycles -> Tx=1, Empty=1, Full=0, Busy=0, Overflow=0.
- Single OUT_Ld with DIn=16'hA55A at edge N:
  - Tx falls at N+2.
  - Line decodes 0xA5 then 0x5A.
  - Busy falls after 80 cycles of frame time; Empty=1.
- Six consecutive OUT_Ld cycles with words 0x0001..0x0006:
  - 0x0001 popped immediately; 0x0002..0x0005 buffered (Full=1).
  - 0x0006 dropped; Overflow=1.
  - Exactly five words transmitted in order.
- FIFO full and FSM finishing STOP; OUT_Ld on the pop cycle -> word accepted, Full stays 1, Overflow stays 0, word later transmitted.
- Reset asserted mid-DATA of 0x3C -> Tx=1 on the next edge, Empty=1, Busy=0; no further line activity.
- OUTPUT_PORT_HEX_EN defined, DIn=16'h1F0C -> line decodes 0x31, 0x46, 0x30, 0x43, 0x0D, 0x0A in 240 cycles.
